// File: rtl/data_mem_responder.sv
// data_mem_responder
//
// Memory-side responder for the data memory control interface. It holds a byte-addressed,
// little-endian array of 64-bit doublewords. Each request takes LATENCY cycles per doubleword
// beat. A request whose bytes cross a doubleword boundary takes two beats. Completion is
// reported with a one-cycle rvalid pulse.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   en           request valid, sampled in IDLE or RESP only
//   wea          1 = store, 0 = load
//   sign_extend  load extension: 1 = sign, 0 = zero
//   bit_width    access size code (0 = byte, 1 = half, 2 = word, 3 = double)
//   addr         byte address
//   wdata        right-aligned store data
//   mem_stall    registered busy flag, high while a request is in flight
//   rdata        extended load result (0 for stores), valid with rvalid
//   rvalid       one-cycle completion pulse
//   addr_err     qualifies rvalid: some beat hit a doubleword index >= DEPTH

module data_mem_responder #(
    parameter int unsigned MEM_BIT_WIDTH = 2,
    parameter int unsigned ADDR_WIDTH    = 16,
    parameter int unsigned DEPTH         = 1024,
    parameter int unsigned LATENCY       = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     wea,
    input  logic                     sign_extend,
    input  logic [MEM_BIT_WIDTH-1:0] bit_width,
    input  logic [ADDR_WIDTH-1:0]    addr,
    input  logic [63:0]              wdata,
    output logic                     mem_stall,
    output logic [63:0]              rdata,
    output logic                     rvalid,
    output logic                     addr_err
);

    // One spare index bit so that the second beat of a request at the top of the address
    // space is seen as out of range instead of wrapping to doubleword 0.
    localparam int unsigned IdxW  = ADDR_WIDTH - 2;
    localparam int unsigned MemAw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned Lat   = (LATENCY < 1) ? 1 : LATENCY;
    localparam int unsigned CntW  = (Lat > 1) ? $clog2(Lat) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Lat - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBeat0 = 2'd1,
        StBeat1 = 2'd2,
        StResp  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic              wea_q, wea_d;
    logic              se_q, se_d;
    logic [MEM_BIT_WIDTH-1:0] bw_q, bw_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [63:0]       rbuf_q, rbuf_d;       // right-aligned load bytes gathered so far
    logic              err_q, err_d;         // any beat of this request out of range
    logic              mem_stall_q, mem_stall_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              addr_err_q, addr_err_d;

    logic [63:0]       mem [DEPTH];

    // Request geometry, all derived from the captured request.
    logic [1:0]        sz;
    logic [3:0]        nbytes;
    logic [2:0]        off;
    int                end_b;
    logic              span;
    logic [6:0]        sh0, sh1;
    logic [7:0]        be0, be1;
    logic [IdxW-1:0]   idx0, idx1, cur_idx;
    logic              in_range;
    logic [MemAw-1:0]  mem_idx;
    logic [63:0]       rd_word;
    logic [63:0]       rd_beat0, rd_beat1;
    logic              last;
    logic              mem_we;
    logic [7:0]        mem_be;
    logic [63:0]       mem_wd;

    function automatic logic [63:0] extend(input logic [63:0] v, input logic [1:0] s,
                                           input logic sx);
        logic [63:0] r;
        case (s)
            2'd0:    r = {{56{sx & v[7]}}, v[7:0]};
            2'd1:    r = {{48{sx & v[15]}}, v[15:0]};
            2'd2:    r = {{32{sx & v[31]}}, v[31:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    always_comb begin
        sz     = 2'(bw_q);
        nbytes = 4'd1 << sz;
        off    = addr_q[2:0];
        end_b  = int'(off) + int'(nbytes);
        span   = end_b > 8;
        // Beat 0 bytes move by off lanes; beat 1 picks up the bytes beyond lane 7.
        sh0    = {1'b0, off, 3'b000};
        sh1    = 7'd64 - sh0;
        for (int i = 0; i < 8; i++) begin
            be0[i] = (i >= int'(off)) && (i < end_b);
            be1[i] = (i + 8) < end_b;
        end

        idx0     = IdxW'(addr_q[ADDR_WIDTH-1:3]);
        idx1     = idx0 + 1'b1;
        cur_idx  = (state_q == StBeat1) ? idx1 : idx0;
        in_range = 32'(cur_idx) < 32'(DEPTH);
        mem_idx  = cur_idx[MemAw-1:0];
        rd_word  = in_range ? mem[mem_idx] : 64'd0;
        rd_beat0 = rd_word >> sh0;
        rd_beat1 = rbuf_q | (rd_word << sh1);

        last   = cnt_q == LastCnt;
        mem_we = wea_q && last && in_range &&
                 ((state_q == StBeat0) || (state_q == StBeat1));
        mem_be = (state_q == StBeat1) ? be1 : be0;
        mem_wd = (state_q == StBeat1) ? (wdata_q >> sh1) : (wdata_q << sh0);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wea_d      = wea_q;
        se_d       = se_q;
        bw_d       = bw_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        addr_err_d = addr_err_q;

        unique case (state_q)
            StIdle, StResp: begin
                if (en) begin
                    state_d = StBeat0;
                    cnt_d   = '0;
                    addr_d  = addr;
                    wea_d   = wea;
                    se_d    = sign_extend;
                    bw_d    = bit_width;
                    wdata_d = wdata;
                    rbuf_d  = '0;
                    err_d   = 1'b0;
                end else begin
                    state_d = StIdle;
                end
            end
            StBeat0: begin
                if (last) begin
                    cnt_d  = '0;
                    err_d  = !in_range;
                    rbuf_d = rd_beat0;
                    if (span) begin
                        state_d = StBeat1;
                    end else begin
                        state_d    = StResp;
                        addr_err_d = !in_range;
                        rdata_d    = wea_q ? 64'd0 : extend(rd_beat0, sz, se_q);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBeat1: begin
                if (last) begin
                    cnt_d      = '0;
                    err_d      = err_q | !in_range;
                    state_d    = StResp;
                    addr_err_d = err_q | !in_range;
                    rdata_d    = wea_q ? 64'd0 : extend(rd_beat1, sz, se_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so mem_stall has no path from en.
        mem_stall_d = (state_d == StBeat0) || (state_d == StBeat1);
        rvalid_d    = state_d == StResp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            wea_q       <= 1'b0;
            se_q        <= 1'b0;
            bw_q        <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            err_q       <= 1'b0;
            mem_stall_q <= 1'b0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wea_q       <= wea_d;
            se_q        <= se_d;
            bw_q        <= bw_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            err_q       <= err_d;
            mem_stall_q <= mem_stall_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            addr_err_q  <= addr_err_d;
        end
    end

    // Array contents are not reset. While rst_n is low the state is IDLE, so no commit occurs.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (mem_be[i]) begin
                    mem[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
                end
            end
        end
    end

    assign mem_stall = mem_stall_q;
    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign addr_err  = addr_err_q;

endmodule
